// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze RAM between the solver (S) and host (H).
// The current owner may hold the port with a lock for a bounded run of consecutive grants.
module maze_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_lock,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              h_req,
  input  logic              h_lock,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S    = 2'd1,
    OWN_H    = 2'd2
  } owner_t;

  localparam logic [4:0] LOCK_LIM = 5'(LOCK_MAX);

  owner_t            owner_q, owner_d;
  logic              last_h_q, last_h_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic              s_rvalid_q, s_rvalid_d;
  logic              h_rvalid_q, h_rvalid_d;

  logic              own_req, own_lock, own_wr, oth_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              act, keep, served_h;

  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    oth_req   = 1'b0;
    case (owner_q)
      OWN_S: begin
        own_req   = s_req;
        own_lock  = s_lock;
        own_wr    = s_wr;
        own_addr  = s_addr;
        own_wdata = s_wdata;
        oth_req   = h_req;
      end
      OWN_H: begin
        own_req   = h_req;
        own_lock  = h_lock;
        own_wr    = h_wr;
        own_addr  = h_addr;
        own_wdata = h_wdata;
        oth_req   = s_req;
      end
      default: ;
    endcase

    act = (owner_q != OWN_NONE) && own_req;
    // lock_cnt_q counts earlier locked grants of this tenure; the current one is number lock_cnt_q+1
    keep = act && (!oth_req || (own_lock && (({1'b0, lock_cnt_q} + 5'd1) < LOCK_LIM)));
    // The current owner counts as served in this cycle, so a tie goes to the other side
    served_h = (owner_q == OWN_NONE) ? last_h_q : (owner_q == OWN_H);

    if (keep) begin
      owner_d = owner_q;
    end else if (s_req && h_req) begin
      owner_d = served_h ? OWN_S : OWN_H;
    end else if (s_req) begin
      owner_d = OWN_S;
    end else if (h_req) begin
      owner_d = OWN_H;
    end else begin
      owner_d = OWN_NONE;
    end
    last_h_d = served_h;

    lock_cnt_d = '0;
    if (keep && own_lock) begin
      lock_cnt_d = ({1'b0, lock_cnt_q} < LOCK_LIM) ? lock_cnt_q + 4'd1 : lock_cnt_q;
    end

    mem_addr = act ? own_addr : '0;
    mem_wr   = act && own_wr;
    mem_rd   = act && !own_wr;
    mem_din  = (act && own_wr) ? own_wdata : '0;

    s_rvalid_d = mem_rd && (owner_q == OWN_S);
    h_rvalid_d = mem_rd && (owner_q == OWN_H);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      last_h_q   <= 1'b1;
      lock_cnt_q <= '0;
      s_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_h_q   <= last_h_d;
      lock_cnt_q <= lock_cnt_d;
      s_rvalid_q <= s_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
    end
  end

  assign s_gnt    = (owner_q == OWN_S);
  assign h_gnt    = (owner_q == OWN_H);
  assign s_rvalid = s_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign s_rdata  = s_rvalid_q ? mem_dout : '0;
  assign h_rdata  = h_rvalid_q ? mem_dout : '0;
  assign busy     = s_gnt | h_gnt | s_rvalid_q | h_rvalid_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios plus random traffic, every cycle compared
// against a rule-level arbitration model with its own shadow copy of the maze RAM.
module tb_maze_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 1;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_req = 0, s_lock = 0, s_wr = 0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic          h_req = 0, h_lock = 0, h_wr = 0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          s_gnt, s_rvalid, h_gnt, h_rvalid;
  logic [DW-1:0] s_rdata, h_rdata, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr, mem_rd, busy;

  maze_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_lock(s_lock), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .h_req(h_req), .h_lock(h_lock), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  function automatic logic pat(int i);
    return (i % 3) == 2;
  endfunction

  // Maze RAM: registered read, one cycle after mem_rd
  logic [DW-1:0] ram [256];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_din;
    end
    if (mem_rd) mem_dout <= ram[mem_addr];
  end

  // Reference model: owner 0=none 1=S 2=H
  int   m_owner, m_last, m_run;
  bit   m_pend_s, m_pend_h, m_done_s, m_done_h;
  logic m_pdata_s, m_pdata_h;
  logic shadow [256];

  int n_chk = 0;
  int n_fail = 0;

  logic          o_sgnt, o_hgnt, o_mwr, o_mrd, o_srv, o_hrv;
  logic [DW-1:0] o_srd, o_hrd;
  logic [AW-1:0] o_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_run = 0;
    m_pend_s = 0; m_pend_h = 0; m_done_s = 0; m_done_h = 0;
    m_pdata_s = 0; m_pdata_h = 0;
  endtask

  task automatic model_edge();
    bit rq[3];
    bit lk[3];
    bit act, keep;
    int o, oth, run, served, nxt;
    if (rst) begin
      model_reset();
      return;
    end
    rq[0] = 0; lk[0] = 0;
    rq[1] = s_req; lk[1] = s_lock;
    rq[2] = h_req; lk[2] = h_lock;
    o   = m_owner;
    oth = (o == 1) ? 2 : 1;
    act = (o != 0) && rq[o];
    m_done_s = act && (o == 1);
    m_done_h = act && (o == 2);
    m_pend_s = m_done_s && !s_wr;
    m_pend_h = m_done_h && !h_wr;
    m_pdata_s = shadow[s_addr];
    m_pdata_h = shadow[h_addr];
    if (m_done_s && s_wr) shadow[s_addr] = s_wdata;
    if (m_done_h && h_wr) shadow[h_addr] = h_wdata;
    run  = (act && lk[o]) ? m_run + 1 : 0;
    keep = act && (!rq[oth] || (lk[o] && run < LM));
    served = (o != 0) ? o : m_last;
    if (keep) nxt = o;
    else if (rq[1] && rq[2]) nxt = 3 - served;
    else if (rq[1]) nxt = 1;
    else if (rq[2]) nxt = 2;
    else nxt = 0;
    m_run   = keep ? run : 0;
    m_last  = served;
    m_owner = nxt;
  endtask

  // One clock cycle: compare at negedge, advance the model at posedge, return at posedge+1
  task automatic cyc();
    bit s_act, h_act;
    logic [AW-1:0] e_addr;
    logic e_wr, e_rd, e_din;
    @(negedge clk);
    s_act = (m_owner == 1) && s_req;
    h_act = (m_owner == 2) && h_req;
    e_addr = s_act ? s_addr : (h_act ? h_addr : '0);
    e_wr   = (s_act && s_wr) || (h_act && h_wr);
    e_rd   = (s_act && !s_wr) || (h_act && !h_wr);
    e_din  = (s_act && s_wr) ? s_wdata : ((h_act && h_wr) ? h_wdata : 1'b0);
    chk("gnt", 32'({s_gnt, h_gnt}), 32'({m_owner == 1, m_owner == 2}));
    chk("mem", 32'({mem_addr, mem_wr, mem_rd, mem_din}), 32'({e_addr, e_wr, e_rd, e_din}));
    chk("rd_s", 32'({s_rvalid, s_rdata}), 32'({m_pend_s, m_pend_s ? m_pdata_s : 1'b0}));
    chk("rd_h", 32'({h_rvalid, h_rdata}), 32'({m_pend_h, m_pend_h ? m_pdata_h : 1'b0}));
    chk("busy", 32'(busy), 32'((m_owner != 0) || m_pend_s || m_pend_h));
    o_sgnt = s_gnt; o_hgnt = h_gnt; o_mwr = mem_wr; o_mrd = mem_rd; o_addr = mem_addr;
    o_srv = s_rvalid; o_srd = s_rdata; o_hrv = h_rvalid; o_hrd = h_rdata;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ram_init = 1'b1;
    s_req = 0; s_lock = 0; s_wr = 0; s_addr = '0; s_wdata = '0;
    h_req = 0; h_lock = 0; h_wr = 0; h_addr = '0; h_wdata = '0;
    @(posedge clk);
    model_reset();
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    #1;
    ram_init = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int left;
    logic [1:0] exp_g;

    // Single solver read
    do_reset();
    s_req = 1; s_wr = 0; s_addr = 8'h23;
    cyc();
    chk("t1_c0_idle", 32'({o_sgnt, o_hgnt}), 32'(2'b00));
    cyc();
    chk("t1_c1_gnt", 32'({o_sgnt, o_mrd, o_addr}), 32'({1'b1, 1'b1, 8'h23}));
    s_req = 0;
    cyc();
    chk("t1_c2_rvalid", 32'({o_srv, o_srd, o_hgnt}), 32'({1'b1, 1'b1, 1'b0}));
    cyc();

    // Both requesting continuously: strict alternation starting with S
    do_reset();
    s_req = 1; h_req = 1; s_addr = 8'h01; h_addr = 8'h02;
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (k > 0) chk("t2_alt", 32'({o_sgnt, o_hgnt}), (k % 2 == 1) ? 32'd2 : 32'd1);
    end

    // Locked write then unlocked read, host waiting
    do_reset();
    s_req = 1; s_lock = 1; s_wr = 1; s_addr = 8'h10; s_wdata = 1;
    h_req = 1; h_wr = 0; h_addr = 8'h10;
    cyc();
    cyc();
    chk("t3_c1", 32'({o_sgnt, o_hgnt, o_mwr}), 32'(3'b101));
    s_lock = 0; s_wr = 0; s_addr = 8'h11;
    cyc();
    chk("t3_c2", 32'({o_sgnt, o_hgnt, o_mrd}), 32'(3'b101));
    s_req = 0;
    cyc();
    chk("t3_c3", 32'({o_sgnt, o_hgnt, o_srv, o_srd}), 32'({1'b0, 1'b1, 1'b1, pat(32'h11)}));
    h_req = 0;
    cyc();
    chk("t3_hread", 32'({o_hrv, o_hrd}), 32'(2'b11));
    cyc();

    // Lock run bounded at LOCK_MAX with host waiting
    do_reset();
    s_req = 1; s_lock = 1; s_wr = 1; s_addr = 8'h50; s_wdata = 1;
    h_req = 1; h_wr = 0; h_addr = 8'h30;
    left = 6;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      exp_g = (k == 5) ? 2'b01 : ((k == 9) ? 2'b00 : 2'b10);
      chk("t4_lockrun", 32'({o_sgnt, o_hgnt}), 32'(exp_g));
      if (o_sgnt && s_req) begin
        left--;
        s_addr = s_addr + 8'd1;
        s_wr = ~s_wr;
        if (left == 0) begin
          s_req = 0; s_lock = 0;
        end
      end
      if (o_hgnt && h_req) h_req = 0;
    end

    // Reset while a host read is in flight
    do_reset();
    h_req = 1; h_wr = 0; h_addr = 8'h23;
    cyc();
    rst = 1;
    cyc();
    chk("t5_gnt", 32'({o_hgnt, o_mrd}), 32'(2'b11));
    rst = 0; h_req = 0;
    cyc();
    chk("t5_after", 32'({o_sgnt, o_hgnt, o_hrv, o_srv}), 32'(4'b0000));
    cyc();
    chk("t5_idle", 32'({o_sgnt, o_hgnt}), 32'(2'b00));

    // Host drops req while granted
    do_reset();
    h_req = 1; h_wr = 1; h_addr = 8'h77; h_wdata = 1;
    cyc();
    h_req = 0;
    cyc();
    chk("t6_drop", 32'({o_hgnt, o_mwr, o_mrd}), 32'(3'b100));
    cyc();
    chk("t6_none", 32'({o_sgnt, o_hgnt}), 32'(2'b00));

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_done_s || !s_req) begin
        if ($urandom_range(3) != 0) begin
          s_req = 1; s_wr = 1'($urandom); s_addr = 8'($urandom);
          s_wdata = 1'($urandom); s_lock = ($urandom_range(1) == 0);
        end else begin
          s_req = 0; s_lock = 0;
        end
      end
      if (m_done_h || !h_req) begin
        if ($urandom_range(3) != 0) begin
          h_req = 1; h_wr = 1'($urandom); h_addr = 8'($urandom);
          h_wdata = 1'($urandom); h_lock = ($urandom_range(2) == 0);
        end else begin
          h_req = 0; h_lock = 0;
        end
      end
      rst = ($urandom_range(299) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
Shares the single-port 256x1 maze memory between two requesters: the maze-solver controller (S port: visited-mark writes, neighbour reads) and the host port (H port: maze load before a run, visited-map readout after done/fail). Round-robin arbitration with an optional bounded lock, so the solver can keep a write/read sequence atomic. Sits between the solver controller and the maze RAM in the top-level datapath.

Parameters:
ADDR_W, 8, memory address width (row/col nibbles of an 8-bit location)
DATA_W, 1, memory word width (1 = wall/visited bit)
LOCK_MAX, 4, maximum consecutive locked grants before a forced handover to a waiting requester (1..15)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
s_req  in  1  solver requests an access
s_lock  in  1  solver asks to keep the grant after this access
s_wr  in  1  1 = write, 0 = read
s_addr  in  ADDR_W  solver address
s_wdata  in  DATA_W  solver write data
s_gnt  out  1  solver access performed this cycle
s_rvalid  out  1  solver read data valid
s_rdata  out  DATA_W  solver read data
h_req, h_lock, h_wr, h_addr, h_wdata  in  1,1,1,ADDR_W,DATA_W  host equivalents
h_gnt, h_rvalid  out  1  host equivalents
h_rdata  out  DATA_W  host read data
mem_addr  out  ADDR_W  RAM address
mem_wr  out  1  RAM write strobe
mem_rd  out  1  RAM read strobe
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data, valid 1 cycle after mem_rd
busy  out  1  a grant or read is in flight

Behaviour:
- Reset (synchronous): s_gnt=h_gnt=0, s_rvalid=h_rvalid=0, owner=NONE, last_served=H (first tie goes to S), lock_cnt=0; in-flight read is discarded (no rvalid after reset).
- Owner FSM states: NONE, S, H. s_gnt/h_gnt are registered = (owner==S)/(owner==H); never both high.
- Next owner (evaluated every posedge from current req/lock):
  - keep current owner if its req=1, its lock=1 and lock_cnt<LOCK_MAX (or the other req=0);
  - else both req → requester != last_served;
  - else single req → that requester; no req → NONE.
- last_served updates to the owner on every granted cycle. lock_cnt increments on each granted cycle with owner kept by lock, saturates at LOCK_MAX, clears on owner change or on lock=0.
- Latency: req first sampled at edge k → gnt high in cycle k+1 at the earliest. Requester holds req/wr/addr/wdata stable until it sees gnt; the access takes place in every cycle with gnt=1 and req=1 (back-to-back accesses allowed, one per cycle).
- mem_addr/mem_wr/mem_rd/mem_din are combinational muxes of the owner's inputs, gated by gnt&req; mem_wr=mem_rd=0 when owner=NONE or the owner's req dropped. mem_addr=0 when idle.
- Reads: rvalid is registered (mem_rd & owner) and asserts exactly 1 cycle after the grant cycle; rdata = mem_dout while rvalid, else 0. A read's rvalid still fires even if ownership moved in the meantime.
- Forced handover: when lock_cnt==LOCK_MAX and the other req=1, ownership passes for at least one grant; the former owner re-enters round robin.
- busy = s_gnt|h_gnt|s_rvalid|h_rvalid.
- Address/data widths pass through unmodified; no wrap logic required.

Test Plan:
- Reset then s_req=1, rd addr=0x23 with RAM[0x23]=1 → s_gnt in cycle 1, mem_rd=1 addr=0x23, s_rvalid=1 s_rdata=1 in cycle 2; h_gnt stays 0.
- s_req and h_req both asserted from reset → grants alternate S,H,S,H each cycle; no cycle with both gnts.
- Solver wr 0x10 data 1 with s_lock=1, then rd 0x11, h_req held high → S holds 2 consecutive grants, H granted the following cycle.
- s_lock held high with 6 queued accesses and LOCK_MAX=4, h_req=1 → S granted 4 cycles, H granted the 5th, S resumes afterwards.
- Host read granted, rst asserted in the rvalid-pending cycle → h_rvalid=0 next cycle, all gnts 0, owner NONE.
- h_req dropped while h_gnt=1 → mem_wr=mem_rd=0 that cycle, owner NONE next cycle.
